// File: rtl/biquad_mac_sequencer.sv
// Direct-Form-I biquad sequencer driving an external 16x16 accumulate-MAC.
// Per sample: clear the MAC, issue five operand pairs, wait out its latency, then saturate the result.
module biquad_mac_sequencer #(
  parameter int unsigned MAC_LATENCY = 3,
  parameter int unsigned DW          = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DW-1:0]     sample_in,
  input  logic              sample_valid,
  input  logic [DW-1:0]     b0,
  input  logic [DW-1:0]     b1,
  input  logic [DW-1:0]     b2,
  input  logic [DW-1:0]     a1,
  input  logic [DW-1:0]     a2,
  output logic              mac_rst,
  output logic              mac_ce,
  output logic [DW-1:0]     mac_a,
  output logic [DW-1:0]     mac_b,
  input  logic [2*DW-1:0]   mac_result,
  output logic [DW-1:0]     y_out,
  output logic              y_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int unsigned AW  = 2 * DW;
  localparam int unsigned TCW = 3;
  localparam int unsigned WCW = 4;
  localparam logic [TCW-1:0] TERM_LAST = TCW'(4);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MAC_LATENCY);
  localparam logic [DW-1:0]  POS_MAX   = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]  NEG_MIN   = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE
  } state_t;

  state_t         state_q, state_d;
  logic [TCW-1:0] term_q, term_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic [DW-1:0]  x_q, x_d, b0_q, b0_d, b1_q, b1_d, b2_q, b2_d, a1_q, a1_d, a2_q, a2_d;
  logic [DW-1:0]  x1_q, x1_d, x2_q, x2_d, y1_q, y1_d, y2_q, y2_d;
  logic           mac_rst_q, mac_rst_d, mac_ce_q, mac_ce_d;
  logic [DW-1:0]  mac_a_q, mac_a_d, mac_b_q, mac_b_d;
  logic [DW-1:0]  y_out_q, y_out_d;
  logic           y_valid_q, y_valid_d, busy_q, busy_d, overrun_q, overrun_d;
  logic [AW-1:0]  y_full;
  logic [DW-1:0]  y_sat;

  // Saturating negation: the most negative value has no positive twin.
  function automatic logic [DW-1:0] neg_sat(input logic [DW-1:0] v);
    if (v == NEG_MIN) return POS_MAX;
    return DW'(~v + DW'(1));
  endfunction

  // Scale Q4.28 down to Q2.14; out of range whenever the bits above the result disagree.
  always_comb begin
    y_full = AW'($signed(mac_result) >>> (DW - 2));
    y_sat  = y_full[DW-1:0];
    if (!((&y_full[AW-1:DW-1]) || !(|y_full[AW-1:DW-1]))) begin
      y_sat = y_full[AW-1] ? NEG_MIN : POS_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      term_q    <= '0;
      wait_q    <= '0;
      x_q       <= '0;
      b0_q      <= '0;
      b1_q      <= '0;
      b2_q      <= '0;
      a1_q      <= '0;
      a2_q      <= '0;
      x1_q      <= '0;
      x2_q      <= '0;
      y1_q      <= '0;
      y2_q      <= '0;
      mac_rst_q <= 1'b0;
      mac_ce_q  <= 1'b0;
      mac_a_q   <= '0;
      mac_b_q   <= '0;
      y_out_q   <= '0;
      y_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      term_q    <= term_d;
      wait_q    <= wait_d;
      x_q       <= x_d;
      b0_q      <= b0_d;
      b1_q      <= b1_d;
      b2_q      <= b2_d;
      a1_q      <= a1_d;
      a2_q      <= a2_d;
      x1_q      <= x1_d;
      x2_q      <= x2_d;
      y1_q      <= y1_d;
      y2_q      <= y2_d;
      mac_rst_q <= mac_rst_d;
      mac_ce_q  <= mac_ce_d;
      mac_a_q   <= mac_a_d;
      mac_b_q   <= mac_b_d;
      y_out_q   <= y_out_d;
      y_valid_q <= y_valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  // MAC controls are registered from the current state, so they trail it by one cycle;
  // WAIT therefore holds one extra state cycle so the last product still gets MAC_LATENCY cycles.
  always_comb begin
    state_d   = state_q;
    term_d    = term_q;
    wait_d    = wait_q;
    x_d       = x_q;
    b0_d      = b0_q;
    b1_d      = b1_q;
    b2_d      = b2_q;
    a1_d      = a1_q;
    a2_d      = a2_q;
    x1_d      = x1_q;
    x2_d      = x2_q;
    y1_d      = y1_q;
    y2_d      = y2_q;
    mac_rst_d = 1'b1;
    mac_ce_d  = 1'b0;
    mac_a_d   = mac_a_q;
    mac_b_d   = mac_b_q;
    y_out_d   = y_out_q;
    y_valid_d = 1'b0;
    overrun_d = overrun_q || (sample_valid && (state_q != S_IDLE));

    case (state_q)
      S_IDLE: begin
        if (sample_valid) begin
          x_d     = sample_in;
          b0_d    = b0;
          b1_d    = b1;
          b2_d    = b2;
          a1_d    = a1;
          a2_d    = a2;
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        mac_rst_d = 1'b0;
        term_d    = '0;
        state_d   = S_ISSUE;
      end
      S_ISSUE: begin
        mac_ce_d = 1'b1;
        case (term_q)
          TCW'(0): begin mac_a_d = b0_q;          mac_b_d = x_q;  end
          TCW'(1): begin mac_a_d = b1_q;          mac_b_d = x1_q; end
          TCW'(2): begin mac_a_d = b2_q;          mac_b_d = x2_q; end
          TCW'(3): begin mac_a_d = neg_sat(a1_q); mac_b_d = y1_q; end
          default: begin mac_a_d = neg_sat(a2_q); mac_b_d = y2_q; end
        endcase
        if (term_q == TERM_LAST) begin
          wait_d  = '0;
          state_d = S_WAIT;
        end else begin
          term_d = term_q + TCW'(1);
        end
      end
      S_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d = S_CAPTURE;
        end else begin
          wait_d = wait_q + WCW'(1);
        end
      end
      S_CAPTURE: begin
        y_out_d   = y_sat;
        y_valid_d = 1'b1;
        x2_d      = x1_q;
        x1_d      = x_q;
        y2_d      = y1_q;
        y1_d      = y_sat;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign mac_rst = mac_rst_q;
  assign mac_ce  = mac_ce_q;
  assign mac_a   = mac_a_q;
  assign mac_b   = mac_b_q;
  assign y_out   = y_out_q;
  assign y_valid = y_valid_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_biquad_mac_sequencer.sv
// Directed bench for biquad_mac_sequencer with a behavioural accumulate-MAC of latency LAT.
module tb_biquad_mac_sequencer;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic [15:0] b0 = '0, b1 = '0, b2 = '0, a1 = '0, a2 = '0;
  logic        mac_rst, mac_ce;
  logic [15:0] mac_a, mac_b;
  logic [31:0] mac_result;
  logic [15:0] y_out;
  logic        y_valid, busy, overrun;

  int nvec = 0;
  int nerr = 0;
  logic [15:0] seen_a[8];
  logic [15:0] seen_b[8];

  biquad_mac_sequencer #(.MAC_LATENCY(LAT), .DW(16)) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .b0(b0), .b1(b1), .b2(b2), .a1(a1), .a2(a2),
    .mac_rst(mac_rst), .mac_ce(mac_ce), .mac_a(mac_a), .mac_b(mac_b),
    .mac_result(mac_result), .y_out(y_out), .y_valid(y_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Accumulator with synchronous active-low clear, followed by LAT pipeline stages.
  logic signed [31:0] acc = '0;
  logic signed [31:0] pipe[LAT];
  always @(posedge clk) begin
    if (!mac_rst) acc <= '0;
    else if (mac_ce) acc <= acc + 32'($signed(mac_a) * $signed(mac_b));
    pipe[0] <= acc;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mac_result = pipe[LAT-1];

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_coef(input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] c2,
                          input logic [15:0] c3, input logic [15:0] c4);
    b0 = c0; b1 = c1; b2 = c2; a1 = c3; a2 = c4;
  endtask

  // Pulse one sample, then count cycles to y_valid and record the operands of every mac_ce cycle.
  task automatic apply(input logic [15:0] x, input bit scramble,
                       output logic [15:0] y, output int lat, output int nce);
    @(negedge clk); sample_in = x; sample_valid = 1'b1;
    @(negedge clk); sample_valid = 1'b0; sample_in = '0;
    if (scramble) set_coef(16'h5555, 16'h5555, 16'h5555, 16'h5555, 16'h5555);
    lat = 0; nce = 0;
    while (y_valid !== 1'b1 && lat < 64) begin
      if (mac_ce === 1'b1) begin
        if (nce < 8) begin seen_a[nce] = mac_a; seen_b[nce] = mac_b; end
        nce++;
      end
      @(negedge clk); lat++;
    end
    y = y_out;
  endtask

  task automatic test_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    if (mac_rst !== 1'b0) begin $display("FAIL rst_mac_rst got %b want 0", mac_rst); nerr++; end
    nvec++;
    if (mac_ce !== 1'b0) begin $display("FAIL rst_mac_ce got %b want 0", mac_ce); nerr++; end
    nvec++;
    if ({mac_a, mac_b} !== 32'h0) begin $display("FAIL rst_ops got %h want 0", {mac_a, mac_b}); nerr++; end
    nvec++;
    if ({y_out, y_valid, busy, overrun} !== 19'h0) begin
      $display("FAIL rst_outs got %h want 0", {y_out, y_valid, busy, overrun}); nerr++;
    end
    nvec++;
    reset = 1'b0;
    @(negedge clk);
    if (mac_rst !== 1'b1) begin $display("FAIL idle_mac_rst got %b want 1", mac_rst); nerr++; end
    nvec++;
  endtask

  task automatic test_passthrough();
    logic [15:0] y; int lat, nce;
    do_reset();
    set_coef(16'h4000, 16'h0, 16'h0, 16'h0, 16'h0);
    apply(16'h2000, 1'b0, y, lat, nce);
    if (y !== 16'h2000) begin $display("FAIL pass_y got %h want 2000", y); nerr++; end
    nvec++;
    if (lat != 11) begin $display("FAIL pass_latency got %0d want 11", lat); nerr++; end
    nvec++;
    if (nce != 5) begin $display("FAIL pass_ce_cycles got %0d want 5", nce); nerr++; end
    nvec++;
    @(negedge clk);
    if (y_valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL pass_after got valid=%b busy=%b want 0 0", y_valid, busy); nerr++;
    end
    nvec++;
  endtask

  task automatic test_operands();
    logic [15:0] y; int lat, nce;
    logic [15:0] ea[5], eb[5];
    ea = '{16'h0001, 16'h0002, 16'h0003, 16'h7FFF, 16'hFFFB};
    eb = '{16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    do_reset();
    set_coef(16'h0001, 16'h0002, 16'h0003, 16'h8000, 16'h0005);
    apply(16'h0100, 1'b1, y, lat, nce);
    for (int i = 0; i < 5; i++) begin
      if (seen_a[i] !== ea[i] || seen_b[i] !== eb[i]) begin
        $display("FAIL ops_term%0d got a=%h b=%h want a=%h b=%h", i, seen_a[i], seen_b[i], ea[i], eb[i]);
        nerr++;
      end
      nvec++;
    end
    if (y !== 16'h0000) begin $display("FAIL ops_y got %h want 0000", y); nerr++; end
    nvec++;
  endtask

  task automatic test_fir();
    logic [15:0] y; int lat, nce;
    logic [15:0] xs[4], ex[4];
    xs = '{16'h4000, 16'h0000, 16'h0000, 16'h0000};
    ex = '{16'h1000, 16'h1000, 16'h1000, 16'h0000};
    do_reset();
    set_coef(16'h1000, 16'h1000, 16'h1000, 16'h0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      apply(xs[i], 1'b0, y, lat, nce);
      if (y !== ex[i]) begin $display("FAIL fir_y%0d got %h want %h", i, y, ex[i]); nerr++; end
      nvec++;
    end
  endtask

  task automatic test_feedback();
    logic [15:0] y; int lat, nce;
    logic [15:0] xs[4], ex[4];
    xs = '{16'h4000, 16'h0000, 16'h0000, 16'h0000};
    ex = '{16'h4000, 16'h2000, 16'h1000, 16'h0800};
    do_reset();
    set_coef(16'h4000, 16'h0, 16'h0, 16'hE000, 16'h0);
    for (int i = 0; i < 4; i++) begin
      apply(xs[i], 1'b0, y, lat, nce);
      if (y !== ex[i]) begin $display("FAIL fb_y%0d got %h want %h", i, y, ex[i]); nerr++; end
      nvec++;
    end
  endtask

  task automatic test_saturation();
    logic [15:0] y; int lat, nce;
    do_reset();
    set_coef(16'h7FFF, 16'h7FFF, 16'h0, 16'h0, 16'h0);
    apply(16'h7FFF, 1'b0, y, lat, nce);
    if (y !== 16'h7FFF) begin $display("FAIL sat_pos1 got %h want 7fff", y); nerr++; end
    nvec++;
    apply(16'h7FFF, 1'b0, y, lat, nce);
    if (y !== 16'h7FFF) begin $display("FAIL sat_pos2 got %h want 7fff", y); nerr++; end
    nvec++;
    do_reset();
    set_coef(16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h0);
    apply(16'h8000, 1'b0, y, lat, nce);
    if (y !== 16'h8000) begin $display("FAIL sat_neg got %h want 8000", y); nerr++; end
    nvec++;
  endtask

  task automatic test_overrun();
    logic [15:0] y; int lat, nce, cnt;
    do_reset();
    set_coef(16'h4000, 16'h4000, 16'h0, 16'h0, 16'h0);
    @(negedge clk); sample_in = 16'h2000; sample_valid = 1'b1;
    @(negedge clk); sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    sample_in = 16'h7FFF; sample_valid = 1'b1;
    @(negedge clk); sample_valid = 1'b0; sample_in = '0;
    cnt = 0;
    while (y_valid !== 1'b1 && cnt < 64) begin @(negedge clk); cnt++; end
    if (y_out !== 16'h2000 || y_valid !== 1'b1) begin
      $display("FAIL ovr_y got %h valid=%b want 2000 1", y_out, y_valid); nerr++;
    end
    nvec++;
    if (overrun !== 1'b1) begin $display("FAIL ovr_flag got %b want 1", overrun); nerr++; end
    nvec++;
    // x1 must hold the accepted 0x2000, not the dropped 0x7FFF.
    apply(16'h0000, 1'b0, y, lat, nce);
    if (y !== 16'h2000) begin $display("FAIL ovr_delay got %h want 2000", y); nerr++; end
    nvec++;
    if (overrun !== 1'b1) begin $display("FAIL ovr_sticky got %b want 1", overrun); nerr++; end
    nvec++;
  endtask

  task automatic test_reset_mid_wait();
    logic [15:0] y; int lat, nce; bit seen;
    do_reset();
    set_coef(16'h4000, 16'h4000, 16'h0, 16'hE000, 16'h0);
    apply(16'h2000, 1'b0, y, lat, nce);
    if (y !== 16'h2000) begin $display("FAIL rw_first got %h want 2000", y); nerr++; end
    nvec++;
    @(negedge clk); sample_in = 16'h1000; sample_valid = 1'b1;
    @(negedge clk); sample_valid = 1'b0; sample_in = '0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    if (mac_rst !== 1'b0 || busy !== 1'b0 || y_out !== 16'h0) begin
      $display("FAIL rw_in_reset got mac_rst=%b busy=%b y=%h want 0 0 0000", mac_rst, busy, y_out); nerr++;
    end
    nvec++;
    reset = 1'b0;
    seen = 1'b0;
    repeat (20) begin @(negedge clk); if (y_valid === 1'b1) seen = 1'b1; end
    if (seen) begin $display("FAIL rw_no_valid got valid pulse want none"); nerr++; end
    nvec++;
    apply(16'h2000, 1'b0, y, lat, nce);
    if (y !== 16'h2000) begin $display("FAIL rw_after got %h want 2000", y); nerr++; end
    nvec++;
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_operands();
    test_fir();
    test_feedback();
    test_saturation();
    test_overrun();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/biquad_mac_sequencer.md
Name: biquad_mac_sequencer

Overview:
Initiator side of the 16x16 accumulate-MAC interface. It computes one Direct-Form-I biquad per band: y = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2, all values Q2.14. For each accepted audio sample it clears the MAC, issues five operand pairs with clock-enable strobes, waits out the MAC latency, then scales and saturates the 32-bit accumulator result into a Q2.14 output sample. One instance per EQ band sits between the sample-rate front end and the band mixer.

Parameters:
MAC_LATENCY, 3, cycles from the last ce-high edge until mac_result holds the final sum (1..15).
DW, 16, sample and coefficient width (Q2.14 when DW=16).

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
sample_in  in  16  signed Q2.14 input sample x[n].
sample_valid  in  1  one-cycle strobe; sample_in is valid while it is high.
b0, b1, b2, a1, a2  in  16 each  signed Q2.14 coefficients; latched when a sample is accepted.
mac_rst  out  1  active-low accumulator clear, driven to the MAC.
mac_ce  out  1  MAC clock enable; one multiply-accumulate per high cycle.
mac_a  out  16  signed coefficient operand.
mac_b  out  16  signed data operand.
mac_result  in  32  signed Q4.28 accumulator value from the MAC.
y_out  out  16  signed Q2.14 filtered sample; holds until the next update.
y_valid  out  1  one-cycle strobe when y_out updates.
busy  out  1  high in every state except IDLE.
overrun  out  1  sticky flag; cleared only by reset.

Behaviour:
- Reset (synchronous, priority over everything else): state=IDLE, mac_rst=0, mac_ce=0, mac_a=mac_b=0, y_out=0, y_valid=0, busy=0, overrun=0, delay lines x1=x2=y1=y2=0. In IDLE with reset low, mac_rst=1.
- Reset asserted mid-operation aborts the sequence. No y_valid is produced, and the delay lines return to 0.
- All outputs are registered.
- FSM: IDLE -> CLR -> ISSUE -> WAIT -> CAPTURE -> IDLE.
- IDLE: when sample_valid=1, latch x=sample_in and all five coefficients, then go to CLR.
- CLR (1 cycle): mac_rst=0, mac_ce=0.
- ISSUE (5 cycles, term index 0..4): mac_ce=1 every cycle.
  - (mac_a, mac_b) = (b0,x), (b1,x1), (b2,x2), (-a1,y1), (-a2,y2).
  - Negation saturates: -(0x8000) -> 0x7FFF.
- WAIT (MAC_LATENCY cycles): mac_ce=0, and mac_a/mac_b hold their last values.
- CAPTURE (1 cycle): compute y = mac_result >>> 14, an arithmetic shift that truncates toward -inf.
  - If mac_result[31:29] are not all equal, saturate: positive -> 0x7FFF, negative -> 0x8000.
  - Else y = mac_result[29:14].
  - Register y_out=y and pulse y_valid.
  - Shift the delay lines: x2<=x1, x1<=x, y2<=y1, y1<=y (the saturated value).
  - Return to IDLE.
- Latency: if a sample is accepted at edge k, y_valid is high in the cycle after edge k+8+MAC_LATENCY (11 cycles at the default). The next sample can be accepted in the cycle after CAPTURE.
- A sample_valid high while busy=1 (including during CAPTURE) is dropped and sets overrun=1. The in-flight computation and the delay lines are unaffected.
- Coefficient port changes after acceptance have no effect until the next sample.

Test Plan:
- Passthrough: b0=0x4000, others 0, sample 0x2000 -> y_out=0x2000; mac_ce high exactly 5 cycles; y_valid 11 cycles after acceptance.
- FIR sum: b0=b1=b2=0x1000, a=0; samples 0x4000, 0, 0, 0 -> y_out = 0x1000, 0x1000, 0x1000, 0x0000.
- Feedback: b0=0x4000, a1=0xE000 (-0.5), a2=0; impulse 0x4000 then zeros -> y_out = 0x4000, 0x2000, 0x1000, 0x0800.
- Saturation: b0=b1=0x7FFF; samples 0x7FFF, 0x7FFF -> y_out=0x7FFF both times. Negative case with b0=0x7FFF and sample 0x8000 -> y_out=0x8000.
- Overrun: second sample_valid 4 cycles after the first -> ignored, overrun=1, result equals the single-sample result, overrun stays set until reset.
- Reset mid-WAIT: assert reset for 1 cycle -> no y_valid, mac_rst=0 during reset, delay lines cleared. A following passthrough sample 0x2000 -> y_out=0x2000.
